// File: rtl/register_file_sb_pkg.sv
// ============================================================================
// register_file_sb_pkg : shared helpers for the register file with scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

package register_file_sb_pkg;

  localparam int REG_ZERO = 0;

  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// regfile_scoreboard : per-register busy bits, RAW hazard detect, issue_ready
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard
  import register_file_sb_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              write_en_i,
  input  logic [ADDR_W-1:0] write_addr_i,
  input  logic              read_en_a_i,
  input  logic [ADDR_W-1:0] read_addr_a_i,
  input  logic              read_en_b_i,
  input  logic [ADDR_W-1:0] read_addr_b_i,
  input  logic              issue_valid_i,
  input  logic              issue_has_rd_i,
  input  logic [ADDR_W-1:0] issue_rd_i,
  output logic              issue_ready_o,
  output logic [DEPTH-1:0]  busy_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             hazard_a;
  logic             hazard_b;
  logic             issue_fire;

  // A completing write to the source cancels the hazard in the same cycle.
  assign hazard_a = read_en_a_i && busy_q[read_addr_a_i]
                    && !(write_en_i && (write_addr_i == read_addr_a_i));
  assign hazard_b = read_en_b_i && busy_q[read_addr_b_i]
                    && !(write_en_i && (write_addr_i == read_addr_b_i));

  assign issue_ready_o = !(hazard_a || hazard_b);
  assign issue_fire    = issue_valid_i && issue_ready_o && issue_has_rd_i
                         && (issue_rd_i != ADDR_W'(REG_ZERO));

  always_comb begin
    busy_d = busy_q;
    busy_d[0] = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      if (reset || flush_i) begin
        busy_d[i] = 1'b0;
      end else if (issue_fire && (issue_rd_i == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;  // newer producer supersedes the completing one
      end else if (write_en_i && (write_addr_i == ADDR_W'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

`default_nettype wire

// File: rtl/register_file_sb.sv
// ============================================================================
// register_file_sb : 2R/1W register file, reg 0 hardwired to zero, optional
//                    write-to-read bypass and integrated RAW scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module register_file_sb
  import register_file_sb_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int BYPASS = 1,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              read_en_a,
  input  logic [ADDR_W-1:0] read_addr_a,
  output logic [WIDTH-1:0]  data_out_a,
  input  logic              read_en_b,
  input  logic [ADDR_W-1:0] read_addr_b,
  output logic [WIDTH-1:0]  data_out_b,
  input  logic              issue_valid,
  input  logic              issue_has_rd,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  input  logic              flush,
  output logic [DEPTH-1:0]  busy
);

  logic [WIDTH-1:0] regs_q [DEPTH];

  // flush intentionally does not gate the write: writeback data is architectural.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (write_en && (write_addr != ADDR_W'(REG_ZERO))) begin
      regs_q[write_addr] <= data_in;
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic en,
                                                 input logic [ADDR_W-1:0] addr);
    read_port = '0;
    if (en && (addr != ADDR_W'(REG_ZERO))) begin
      if ((BYPASS != 0) && write_en && (write_addr == addr)) begin
        read_port = data_in;
      end else begin
        read_port = regs_q[addr];
      end
    end
  endfunction

  always_comb begin
    data_out_a = read_port(read_en_a, read_addr_a);
    data_out_b = read_port(read_en_b, read_addr_b);
  end

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk            (clk),
    .reset          (reset),
    .flush_i        (flush),
    .write_en_i     (write_en),
    .write_addr_i   (write_addr),
    .read_en_a_i    (read_en_a),
    .read_addr_a_i  (read_addr_a),
    .read_en_b_i    (read_en_b),
    .read_addr_b_i  (read_addr_b),
    .issue_valid_i  (issue_valid),
    .issue_has_rd_i (issue_has_rd),
    .issue_rd_i     (issue_rd),
    .issue_ready_o  (issue_ready),
    .busy_o         (busy)
  );

endmodule

`default_nettype wire

// File: tb/tb_register_file_sb.sv
// ============================================================================
// tb_register_file_sb : vector-table bench driving a bypass and a non-bypass
//                       instance with shared stimulus
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        write_en = 1'b0;
  logic [2:0]  write_addr = '0;
  logic [31:0] data_in = '0;
  logic        read_en_a = 1'b0;
  logic [2:0]  read_addr_a = '0;
  logic        read_en_b = 1'b0;
  logic [2:0]  read_addr_b = '0;
  logic        issue_valid = 1'b0;
  logic        issue_has_rd = 1'b0;
  logic [2:0]  issue_rd = '0;
  logic        flush = 1'b0;

  logic [31:0] out_a1, out_b1, out_a0, out_b0;
  logic        rdy1, rdy0;
  logic [7:0]  busy1, busy0;

  always #5 clk = ~clk;

  register_file_sb #(.WIDTH(32), .DEPTH(8), .BYPASS(1)) dut_byp (
    .clk(clk), .reset(reset), .write_en(write_en), .write_addr(write_addr),
    .data_in(data_in), .read_en_a(read_en_a), .read_addr_a(read_addr_a),
    .data_out_a(out_a1), .read_en_b(read_en_b), .read_addr_b(read_addr_b),
    .data_out_b(out_b1), .issue_valid(issue_valid), .issue_has_rd(issue_has_rd),
    .issue_rd(issue_rd), .issue_ready(rdy1), .flush(flush), .busy(busy1)
  );

  register_file_sb #(.WIDTH(32), .DEPTH(8), .BYPASS(0)) dut_nobyp (
    .clk(clk), .reset(reset), .write_en(write_en), .write_addr(write_addr),
    .data_in(data_in), .read_en_a(read_en_a), .read_addr_a(read_addr_a),
    .data_out_a(out_a0), .read_en_b(read_en_b), .read_addr_b(read_addr_b),
    .data_out_b(out_b0), .issue_valid(issue_valid), .issue_has_rd(issue_has_rd),
    .issue_rd(issue_rd), .issue_ready(rdy0), .flush(flush), .busy(busy0)
  );

  typedef struct {
    logic        rst, fl, we;
    logic [2:0]  wa;
    logic [31:0] din;
    logic        ra_en;
    logic [2:0]  ra;
    logic        rb_en;
    logic [2:0]  rb;
    logic        iv, hrd;
    logic [2:0]  rd;
    logic [31:0] ea, eb1, eb0;
    logic        erdy;
    logic [7:0]  ebusy;
  } vec_t;

  vec_t        vecs[$];
  logic [7:0]  exp_q[$];
  int          n_checks = 0;
  int          n_err = 0;

  function automatic vec_t mk(input logic rst, fl, we, input logic [2:0] wa,
                              input logic [31:0] din, input logic ra_en,
                              input logic [2:0] ra, input logic rb_en,
                              input logic [2:0] rb, input logic iv, hrd,
                              input logic [2:0] rd, input logic [31:0] ea,
                              input logic [31:0] eb1, eb0, input logic erdy,
                              input logic [7:0] ebusy);
    vec_t v;
    v.rst = rst; v.fl = fl; v.we = we; v.wa = wa; v.din = din;
    v.ra_en = ra_en; v.ra = ra; v.rb_en = rb_en; v.rb = rb;
    v.iv = iv; v.hrd = hrd; v.rd = rd;
    v.ea = ea; v.eb1 = eb1; v.eb0 = eb0; v.erdy = erdy; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; flush = v.fl; write_en = v.we; write_addr = v.wa;
    data_in = v.din; read_en_a = v.ra_en; read_addr_a = v.ra;
    read_en_b = v.rb_en; read_addr_b = v.rb;
    issue_valid = v.iv; issue_has_rd = v.hrd; issue_rd = v.rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [7:0] e;
    //              rst fl we wa  din            ra_en ra rb_en rb iv hrd rd  ea            eb1           eb0           rdy busy
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         1, 3, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         1, 3, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 8'h00));
    vecs.push_back(mk(0, 0, 1, 5, 32'hDEADBEEF,  0, 0, 1, 5, 0, 0, 0, 32'h0,        32'hDEADBEEF, 32'h0,        1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 5, 1, 5, 0, 0, 0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1, 8'h00));
    vecs.push_back(mk(0, 0, 1, 0, 32'hFFFFFFFF,  1, 0, 1, 0, 1, 1, 0, 32'h0,        32'h0,        32'h0,        1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         1, 0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 1, 1, 4, 32'h0,        32'h0,        32'h0,        1, 8'h10));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         1, 4, 1, 5, 1, 1, 6, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0, 8'h10));
    vecs.push_back(mk(0, 0, 1, 4, 32'h12345678,  1, 4, 0, 0, 0, 0, 0, 32'h12345678, 32'h0,        32'h0,        1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         1, 4, 0, 0, 0, 0, 0, 32'h12345678, 32'h0,        32'h0,        1, 8'h00));
    vecs.push_back(mk(0, 0, 1, 2, 32'hA5A5A5A5,  0, 0, 1, 2, 1, 1, 2, 32'h0,        32'hA5A5A5A5, 32'h0,        1, 8'h04));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 1, 1, 1, 32'h0,        32'h0,        32'h0,        1, 8'h06));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 1, 1, 4, 32'h0,        32'h0,        32'h0,        1, 8'h16));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 1, 1, 5, 32'h0,        32'h0,        32'h0,        1, 8'h36));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 1, 1, 6, 32'h0,        32'h0,        32'h0,        1, 8'h76));
    vecs.push_back(mk(0, 1, 1, 1, 32'hCAFEF00D,  1, 1, 0, 0, 1, 1, 3, 32'hCAFEF00D, 32'h0,        32'h0,        1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         1, 1, 1, 1, 0, 0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 1, 8'h00));
    vecs.push_back(mk(1, 0, 1, 7, 32'h1,         1, 5, 1, 1, 1, 1, 3, 32'hDEADBEEF, 32'hCAFEF00D, 32'hCAFEF00D, 1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         1, 5, 1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         1, 7, 1, 2, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 1, 1, 3, 32'h0,        32'h0,        32'h0,        1, 8'h08));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 0, 1, 3, 1, 1, 7, 32'h0,        32'h0,        32'h0,        0, 8'h08));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         0, 3, 0, 3, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 8'h08));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v);
      #2;
      chk($sformatf("v%0d data_out_a", i), out_a1, v.ea);
      chk($sformatf("v%0d data_out_b byp", i), out_b1, v.eb1);
      chk($sformatf("v%0d data_out_b nobyp", i), out_b0, v.eb0);
      chk($sformatf("v%0d issue_ready byp", i), {31'b0, rdy1}, {31'b0, v.erdy});
      chk($sformatf("v%0d issue_ready nobyp", i), {31'b0, rdy0}, {31'b0, v.erdy});
      exp_q.push_back(v.ebusy);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("v%0d busy byp", i), {24'b0, busy1}, {24'b0, e});
      chk($sformatf("v%0d busy nobyp", i), {24'b0, busy0}, {24'b0, e});
      @(negedge clk);
    end

    // Issue-to-busy takes exactly one edge; writeback then clears and stores.
    v = mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 1, 1, 7, 32'h0, 32'h0, 32'h0, 1, 8'h88);
    drive(v);
    #2;
    chk("issue7 busy before edge", {24'b0, busy1}, 32'h08);
    exp_q.push_back(8'h88);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("issue7 busy after edge", {24'b0, busy1}, {24'b0, e});
    @(negedge clk);
    v = mk(0, 0, 1, 7, 32'h00000077, 0, 0, 1, 7, 0, 0, 0, 32'h0, 32'h77, 32'h0, 1, 8'h08);
    drive(v);
    #2;
    chk("wb7 issue_ready", {31'b0, rdy1}, 32'h1);
    chk("wb7 nobyp old data", out_b0, 32'h0);
    exp_q.push_back(8'h08);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("wb7 busy after edge", {24'b0, busy0}, {24'b0, e});
    chk("wb7 nobyp new data", out_b0, 32'h77);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the 8-entry register file.
- Generalised depth and width; two combinational read ports and one synchronous write port; register 0 hardwired to zero.
- Optional write-to-read bypass.
- Integrated scoreboard of per-register busy bits so the decode stage can detect RAW hazards and stall issue.
- Sits between decode (read/issue side) and writeback (write side) in the pipelined MIPS datapath.

Parameters:
- WIDTH, 32, bits per register.
- DEPTH, 8, number of registers; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- write_en  input  1  writeback write strobe.
- write_addr  input  ADDR_W  writeback destination.
- data_in  input  WIDTH  writeback data.
- read_en_a  input  1  port A read enable.
- read_addr_a  input  ADDR_W  port A source.
- data_out_a  output  WIDTH  port A data, combinational.
- read_en_b  input  1  port B read enable.
- read_addr_b  input  ADDR_W  port B source.
- data_out_b  output  WIDTH  port B data, combinational.
- issue_valid  input  1  decode presents an instruction this cycle.
- issue_has_rd  input  1  instruction writes a destination.
- issue_rd  input  ADDR_W  destination to mark busy.
- issue_ready  output  1  instruction may issue (no RAW hazard on enabled sources).
- flush  input  1  pipeline flush; clears all busy bits.
- busy  output  DEPTH  current scoreboard vector, for debug/verification.

Behaviour:
- One clock (clk); synchronous active-high reset (reset). Every flop is updated only on the rising edge of clk.
- Reset: all registers go to 0; busy goes to 0. While reset is high, writes and issues are ignored.
- Combinational outputs during reset follow the rules below, using the stored values.

Storage:
- Write: on the edge with write_en=1 and write_addr!=0, reg[write_addr]<=data_in.
- Writes to address 0 are discarded; reg 0 always reads 0.

Read ports (combinational, identical rules for A and B):
- read_en low -> output 0 (no tri-state; outputs are always driven).
- read_addr==0 -> 0.
- BYPASS=1, write_en=1 and write_addr==read_addr!=0 -> data_in.
- Otherwise -> reg[read_addr].

Scoreboard:
- hazard_x = read_en_x && busy[read_addr_x] && !(write_en && write_addr==read_addr_x). The clearing write cancels the hazard in the same cycle regardless of BYPASS; BYPASS=0 integrators must not rely on this.
- issue_ready = !(hazard_a || hazard_b). It does not depend on issue_valid and is 1 out of reset.
- An issue fires when issue_valid && issue_ready && issue_has_rd && issue_rd!=0.
- Next-state busy bit i is decided by this priority:
  - reset or flush -> 0;
  - issue fires with issue_rd==i -> 1;
  - write_en with write_addr==i -> 0;
  - otherwise hold.
- Set beats clear on the same register in the same cycle, because a newer producer supersedes the completing one.
- flush does not block the register write; data written in the flush cycle is stored.
- busy[0] is constantly 0.
- A stalled instruction (issue_ready=0) sets no bit.
- Write to a non-busy register: data is stored and busy is unchanged.
- Latency: write-to-read is 0 cycles with BYPASS=1, 1 cycle with BYPASS=0. Issue-to-busy is 1 cycle.

Decomposition:
- Shared package: ADDR_W derivation function and the REG_ZERO address constant.
- Sub-module regfile_scoreboard holds the busy vector, hazard logic and issue_ready.
- Storage and read muxing stay in the top module.

Test Plan:
- Reset, then read_en_a=1, read_addr_a=3 -> data_out_a=0, busy=0, issue_ready=1.
- write_en=1, write_addr=5, data_in=32'hDEADBEEF, read_addr_b=5 in the same cycle -> data_out_b=DEADBEEF in that cycle (BYPASS=1), and next cycle with write_en=0 also DEADBEEF. Repeat with BYPASS=0 -> old value in the write cycle, DEADBEEF after the edge.
- write_addr=0, data_in=32'hFFFFFFFF -> reads of address 0 return 0; busy[0] stays 0 after issue_rd=0.
- Issue rd=4 -> busy[4]=1 next cycle. Then read_en_a=1, read_addr_a=4 -> issue_ready=0, and issue_rd=6 does not set busy[6]. A writeback to 4 in a later cycle -> issue_ready=1 in that same cycle, busy[4]=0 after the edge.
- Same cycle: issue rd=2 fires and write_en to addr 2 -> busy[2]=1 after the edge (set wins).
- busy=8'b0111_0110, assert flush with write_en to addr 1 -> busy=0 and reg1 updated. Asserting reset mid-stream -> all registers read 0 next cycle.
